// File: rtl/dlx_bus_pkg.sv
// Shared types and constants for the DLX external bus arbiter.
// State encodings are fixed because they are exported on CURR_STATE for debug.
package dlx_bus_pkg;

    localparam int unsigned DefaultAw      = 32;
    localparam int unsigned DefaultDw      = 32;
    localparam int unsigned DefaultTimeout = 255;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSetup   = 2'd1,
        StWaitAck = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam logic [1:0] GntNone = 2'b00;
    localparam logic [1:0] GntM0   = 2'b01;
    localparam logic [1:0] GntM1   = 2'b10;

endpackage

// File: rtl/dlx_bus_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the master that did not own the last transfer wins.
// Purely combinational; the caller decides when the pick is used.
module rr_arbiter2
    import dlx_bus_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_m1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GntNone;
        if (req0 && req1) begin
            gnt = last_m1 ? GntM0 : GntM1;
        end else if (req0) begin
            gnt = GntM0;
        end else if (req1) begin
            gnt = GntM1;
        end
    end

endmodule

// File: rtl/dlx_bus_arbiter.sv
// DLX external memory bus owner: shares the AS_N/WR_N/ACK_N handshake between the monitor (M0)
// and the core (M1), one SETUP -> WAIT_ACK -> RELEASE transfer at a time, with an ACK watchdog.
module dlx_bus_arbiter
    import dlx_bus_pkg::*;
#(
    parameter int unsigned AW      = DefaultAw,
    parameter int unsigned DW      = DefaultDw,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          M0_REQ,
    input  logic          M0_WE,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [DW-1:0] M0_WDATA,
    output logic          M0_DONE,
    output logic          M0_ERR,
    input  logic          M1_REQ,
    input  logic          M1_WE,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M1_WDATA,
    output logic          M1_DONE,
    output logic          M1_ERR,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] BUS_ADDR,
    output logic [DW-1:0] BUS_DO,
    input  logic [DW-1:0] BUS_DI,
    output logic          AS_N,
    output logic          WR_N,
    input  logic          ACK_N,
    output logic [1:0]    GNT,
    output logic          BUSY,
    output logic [1:0]    CURR_STATE
);

    localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e          state_q, state_d;
    logic [WdW-1:0]  watchdog_q, watchdog_d;
    logic [1:0]      last_gnt_q, last_gnt_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic            we_q, we_d;
    logic            as_n_q, as_n_d;
    logic            wr_n_q, wr_n_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_do_q, bus_do_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      pick;
    logic            wd_expired;

    rr_arbiter2 u_arb (
        .req0    (M0_REQ),
        .req1    (M1_REQ),
        .last_m1 (last_gnt_q == GntM1),
        .gnt     (pick)
    );

    assign wd_expired = (watchdog_q == WdW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            watchdog_q <= '0;
            last_gnt_q <= GntM1;
            gnt_q      <= GntNone;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            we_q       <= 1'b0;
            as_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            bus_addr_q <= '0;
            bus_do_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            watchdog_q <= watchdog_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            we_q       <= we_d;
            as_n_q     <= as_n_d;
            wr_n_q     <= wr_n_d;
            bus_addr_q <= bus_addr_d;
            bus_do_q   <= bus_do_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (pick != GntNone) state_d = StSetup;
            StSetup:   state_d = StWaitAck;
            StWaitAck: begin
                if (!ACK_N) begin
                    state_d = StRelease;
                end else if (wd_expired) begin
                    state_d = StIdle;
                end
            end
            StRelease: if (ACK_N) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of every registered output; DONE/ERR default low so they pulse once.
    always_comb begin
        watchdog_d = watchdog_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        we_d       = we_q;
        as_n_d     = as_n_q;
        wr_n_d     = wr_n_q;
        bus_addr_d = bus_addr_q;
        bus_do_d   = bus_do_q;
        rdata_d    = rdata_q;
        case (state_q)
            StIdle: begin
                if (pick != GntNone) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    if (pick == GntM0) begin
                        bus_addr_d = M0_ADDR;
                        bus_do_d   = M0_WDATA;
                        we_d       = M0_WE;
                    end else begin
                        bus_addr_d = M1_ADDR;
                        bus_do_d   = M1_WDATA;
                        we_d       = M1_WE;
                    end
                end
            end
            StSetup: begin
                as_n_d     = 1'b0;
                wr_n_d     = ~we_q;
                watchdog_d = '0;
            end
            StWaitAck: begin
                if (!ACK_N) begin
                    as_n_d = 1'b1;
                    wr_n_d = 1'b1;
                    done_d = gnt_q;
                    if (!we_q) rdata_d = BUS_DI;
                end else if (wd_expired) begin
                    as_n_d = 1'b1;
                    wr_n_d = 1'b1;
                    err_d  = gnt_q;
                    gnt_d  = GntNone;
                end else begin
                    watchdog_d = watchdog_q + WdW'(1);
                end
            end
            StRelease: if (ACK_N) gnt_d = GntNone;
            default: begin
                watchdog_d = '0;
                last_gnt_d = GntM1;
                gnt_d      = GntNone;
                we_d       = 1'b0;
                as_n_d     = 1'b1;
                wr_n_d     = 1'b1;
                bus_addr_d = '0;
                bus_do_d   = '0;
                rdata_d    = '0;
            end
        endcase
    end

    assign M0_DONE    = done_q[0];
    assign M1_DONE    = done_q[1];
    assign M0_ERR     = err_q[0];
    assign M1_ERR     = err_q[1];
    assign RDATA      = rdata_q;
    assign BUS_ADDR   = bus_addr_q;
    assign BUS_DO     = bus_do_q;
    assign AS_N       = as_n_q;
    assign WR_N       = wr_n_q;
    assign GNT        = gnt_q;
    assign BUSY       = (state_q != StIdle);
    assign CURR_STATE = state_q;

endmodule
